multdiv_ctrl: RTL and testbench
===============================

# multdiv_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO architectural registers. It sits beside the execute stage, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, and holds the pipeline with a stall request until the result is written. Only then does the pipeline advance. The HI/LO values it produces feed the execute/writeback path for MFHI/MFLO.

## Interface
Parameters:
- MUL_CYCLES, 3, cycles spent in MUL_WAIT (must be >= 1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- e_valid  in  1  execute-stage instruction valid
- e_op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 treated as NONE
- e_src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- e_src_b  in  32  rt operand (divisor / multiplier)
- flush  in  1  exception/kill from a later stage
- stall_req  out  1  hold the execute stage
- done  out  1  one-cycle pulse when a MULT/DIV result is written
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- One clock; reset is synchronous and active-high.
- States: IDLE, MUL_WAIT, DIV_RUN, DIV_FIX.
- Start condition: IDLE & e_valid & !flush & op in {MULT, MULTU, DIV, DIVU}. Called "accept".
- MULT/MULTU on accept:
  - Register the 64-bit signed/unsigned product.
  - cnt <= MUL_CYCLES-1; go to MUL_WAIT.
- MUL_WAIT:
  - cnt != 0: decrement.
  - cnt == 0: {hi, lo} <= product; done = 1; go to IDLE.
- DIV/DIVU on accept, divisor != 0:
  - Latch |a| and |b| (DIV) or the raw values (DIVU), plus the sign flags.
  - iter <= 0; go to DIV_RUN.
- DIV_RUN: restoring division, one quotient bit per cycle, 32 cycles; after the 32nd cycle go to DIV_FIX.
- DIV_FIX:
  - DIV only: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
  - lo <= quotient; hi <= remainder; done = 1; go to IDLE.
- Divide by zero: accept goes straight to DIV_FIX with quotient 0xFFFFFFFF and remainder e_src_a (both DIV and DIVU).
- 0x80000000 / 0xFFFFFFFF (DIV): lo = 0x80000000, hi = 0.
- MTHI/MTLO: in IDLE with e_valid & !flush, write hi/lo at the clock edge. No stall, no done.
- stall_req = !rst & !flush & ((accept) | (state == MUL_WAIT & cnt != 0) | state == DIV_RUN).
  - It is low in the completion cycle (MUL_WAIT with cnt == 0, or DIV_FIX), so the instruction leaves execute in that cycle.
- Outside IDLE, e_valid/e_op are ignored; the next instruction cannot start in the completion cycle.
- flush:
  - Any state: next state is IDLE, no HI/LO write, done = 0.
  - Flush beats completion in the same cycle.
  - Flush in IDLE blocks accept and MTHI/MTLO.

## Timing
- Reset values: state IDLE, hi = 0, lo = 0, done = 0, stall_req = 0, cnt = 0, iter = 0.
- Reset mid-operation aborts with no HI/LO write.
- MULT accepted at cycle T:
  - stall_req high T..T+MUL_CYCLES-1.
  - Write and done at T+MUL_CYCLES.
  - New hi/lo visible at T+MUL_CYCLES+1.
- DIV accepted at T:
  - stall_req high T..T+32.
  - DIV_FIX, write and done at T+33.
  - Visible at T+34.
- Divide by zero accepted at T: DIV_FIX at T+1; visible at T+2.
- MTHI/MTLO at T: visible at T+1.
- hi/lo are registered; no same-cycle bypass.
- Arithmetic: 64-bit remainder/quotient shift register (hi part 33 bits for the subtract); all sign corrections are 2's complement modulo 2^32.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5, MUL_CYCLES=3 -> stall_req high 3 cycles, done at T+3, hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV a=-7, b=2 -> 33 stall cycles, done at T+33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU 5/0 -> done at T+1, lo=0xFFFFFFFF, hi=5.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in back-to-back cycles -> no stall, hi/lo updated one cycle after each; MULT issued next overwrites both.
- Flush during DIV_RUN iteration 10, and flush coincident with the MUL_WAIT completion cycle -> state IDLE next cycle, stall_req low, done=0, hi/lo keep prior values.
- rst asserted mid-DIV -> next cycle hi=lo=0, stall_req=0, IDLE; a fresh DIV then completes normally.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Multiply/divide sequencer that owns the HI/LO registers: multi-cycle MULT/DIV
// with a pipeline stall request, and single-cycle MTHI/MTLO writes.
module multdiv_ctrl #(
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_valid,
  input  logic [2:0]  e_op,
  input  logic [31:0] e_src_a,
  input  logic [31:0] e_src_b,
  input  logic        flush,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_RUN, DIV_FIX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    iter_q, iter_d;
  logic [63:0]   prod_q, prod_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   dvsr_q, dvsr_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic          is_mul, is_div, op_signed, accept;
  logic [63:0]   mul_a, mul_b;
  logic [31:0]   abs_a, abs_b;
  logic [33:0]   trial;

  always_comb begin
    is_mul    = (e_op == OP_MULT) || (e_op == OP_MULTU);
    is_div    = (e_op == OP_DIV) || (e_op == OP_DIVU);
    op_signed = (e_op == OP_MULT) || (e_op == OP_DIV);
    accept    = (state_q == IDLE) && e_valid && !flush && (is_mul || is_div);
    mul_a     = op_signed ? {{32{e_src_a[31]}}, e_src_a} : {32'd0, e_src_a};
    mul_b     = op_signed ? {{32{e_src_b[31]}}, e_src_b} : {32'd0, e_src_b};
    abs_a     = (op_signed && e_src_a[31]) ? (~e_src_a + 32'd1) : e_src_a;
    abs_b     = (op_signed && e_src_b[31]) ? (~e_src_b + 32'd1) : e_src_b;
    // Restoring step: shift in the next dividend bit and try the subtract.
    trial     = {1'b0, rem_q, quo_q[31]} - {2'b00, dvsr_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    iter_d    = iter_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_req = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        stall_req = accept;
        if (e_valid) begin
          if (is_mul) begin
            prod_d  = mul_a * mul_b;
            cnt_d   = CW'(MUL_CYCLES - 1);
            state_d = MUL_WAIT;
          end else if (is_div) begin
            if (e_src_b == 32'd0) begin
              quo_d     = 32'hFFFF_FFFF;
              rem_d     = e_src_a;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = DIV_FIX;
            end else begin
              quo_d     = abs_a;
              rem_d     = 32'd0;
              dvsr_d    = abs_b;
              neg_quo_d = op_signed && (e_src_a[31] ^ e_src_b[31]);
              neg_rem_d = op_signed && e_src_a[31];
              iter_d    = 5'd0;
              state_d   = DIV_RUN;
            end
          end else if (e_op == OP_MTHI) begin
            hi_d = e_src_a;
          end else if (e_op == OP_MTLO) begin
            lo_d = e_src_a;
          end
        end
      end
      MUL_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d     = cnt_q - CW'(1);
          stall_req = 1'b1;
        end else begin
          {hi_d, lo_d} = prod_q;
          done         = 1'b1;
          state_d      = IDLE;
        end
      end
      DIV_RUN: begin
        stall_req = 1'b1;
        rem_d     = trial[33] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
        quo_d     = {quo_q[30:0], ~trial[33]};
        iter_d    = iter_q + 5'd1;
        if (iter_q == 5'd31) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        lo_d    = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
        hi_d    = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A kill from a later stage wins over any completion or MTHI/MTLO write.
    if (flush || rst) begin
      state_d   = IDLE;
      hi_d      = hi_q;
      lo_d      = lo_q;
      stall_req = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      iter_q    <= 5'd0;
      prod_q    <= 64'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iter_q    <= iter_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: table vectors, hand-written flush/reset
// sequences and randomized operations checked against an arithmetic model.
module tb_multdiv_ctrl;
  localparam int MC = 3;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic        clk;
  logic        rst;
  logic        e_valid;
  logic [2:0]  e_op;
  logic [31:0] e_src_a;
  logic [31:0] e_src_b;
  logic        flush;
  logic        stall_req;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests;
  int fails;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_done;
    int          exp_stalls;
    string       name;
  } vec_t;

  vec_t vecs[11];

  multdiv_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk       (clk),
    .rst       (rst),
    .e_valid   (e_valid),
    .e_op      (e_op),
    .e_src_a   (e_src_a),
    .e_src_b   (e_src_b),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // Free-running clock, inputs driven on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Arithmetic reference: results derived from 64-bit integer arithmetic.
  function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                   output logic [31:0] r_hi, output logic [31:0] r_lo,
                                   output int r_done, output int r_stalls);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r_hi = cur_hi;
    r_lo = cur_lo;
    r_done = -1;
    r_stalls = 0;
    case (op)
      OP_MULT: begin
        sq = sa * sb;
        r_hi = sq[63:32];
        r_lo = sq[31:0];
        r_done = MC;
        r_stalls = MC;
      end
      OP_MULTU: begin
        uq = ua * ub;
        r_hi = uq[63:32];
        r_lo = uq[31:0];
        r_done = MC;
        r_stalls = MC;
      end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          r_hi = a;
          r_lo = 32'hFFFF_FFFF;
          r_done = 1;
          r_stalls = 1;
        end else begin
          if (op == OP_DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            r_hi = sr[31:0];
            r_lo = sq[31:0];
          end else begin
            uq = ua / ub;
            ur = ua % ub;
            r_hi = ur[31:0];
            r_lo = uq[31:0];
          end
          r_done = 33;
          r_stalls = 33;
        end
      end
      OP_MTHI: r_hi = a;
      OP_MTLO: r_lo = a;
      default: ;
    endcase
  endfunction

  // Issue one instruction, follow it to completion and compare timing and HI/LO.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                               input int exp_done, input int exp_stalls, input string name);
    int k;
    int stalls;
    int done_at;
    int limit;
    k = 0;
    stalls = 0;
    done_at = -1;
    limit = (exp_done < 0) ? 3 : 80;
    @(negedge clk);
    e_valid = 1'b1;
    e_op = op;
    e_src_a = a;
    e_src_b = b;
    while (done_at < 0 && k < limit) begin
      #1;
      if (stall_req) stalls++;
      if (done) done_at = k;
      @(negedge clk);
      e_valid = 1'b0;
      e_op = OP_NONE;
      k++;
    end
    #1;
    checkOutput({name, "_done_cycle"}, done_at, exp_done);
    checkOutput({name, "_stalls"}, stalls, exp_stalls);
    checkOutput({name, "_hi"}, hi, exp_hi);
    checkOutput({name, "_lo"}, lo, exp_lo);
    checkOutput({name, "_done_pulse"}, done, 0);
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  task automatic countDone(input int cycles, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      if (done) seen++;
    end
    checkOutput({name, "_no_done"}, seen, 0);
    checkOutput({name, "_hi_kept"}, hi, model_hi);
    checkOutput({name, "_lo_kept"}, lo, model_lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb, rhi, rlo;
    int          rdone, rstalls;

    tests = 0;
    fails = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    rst = 1'b1;
    flush = 1'b0;
    e_valid = 1'b0;
    e_op = OP_NONE;
    e_src_a = 32'd0;
    e_src_b = 32'd0;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MC, MC, "mult_neg3x5"};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFD, 32'd5,         32'h0000_0004, 32'hFFFF_FFF1, MC, MC, "multu_big"};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33, "div_m7_2"};
    vecs[3]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33, 33, "divu_100_7"};
    vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33, 33, "div_ovf"};
    vecs[5]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1,  1,  "divu_by0"};
    vecs[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1,  1,  "div_neg_by0"};
    vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33, 33, "div_7_m2"};
    vecs[8]  = '{OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MC, MC, "mult_maxpos"};
    vecs[9]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 33, 33, "divu_by1"};
    vecs[10] = '{3'd7,     32'h1111_1111, 32'd3,         32'd0,         32'hFFFF_FFFF, -1, 0,  "op7_none"};

    // Reset state, including a MULT presented while reset is held.
    @(negedge clk);
    e_valid = 1'b1;
    e_op = OP_MULT;
    e_src_a = 32'd9;
    e_src_b = 32'd9;
    #1;
    checkOutput("rst_stall_gated", stall_req, 0);
    checkOutput("rst_done_gated", done, 0);
    @(negedge clk);
    rst = 1'b0;
    e_valid = 1'b0;
    e_op = OP_NONE;
    #1;
    checkOutput("reset_hi", hi, 0);
    checkOutput("reset_lo", lo, 0);
    checkOutput("reset_stall", stall_req, 0);
    checkOutput("reset_done", done, 0);

    for (int i = 0; i < 11; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                    vecs[i].exp_done, vecs[i].exp_stalls, vecs[i].name);

    // Back-to-back MTHI then MTLO, each visible one cycle later, then MULT overwrites both.
    @(negedge clk);
    e_valid = 1'b1;
    e_op = OP_MTHI;
    e_src_a = 32'h1234_5678;
    #1;
    checkOutput("mthi_stall", stall_req, 0);
    checkOutput("mthi_no_bypass", hi, model_hi);
    @(negedge clk);
    e_op = OP_MTLO;
    e_src_a = 32'h9ABC_DEF0;
    #1;
    checkOutput("mtlo_stall", stall_req, 0);
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    checkOutput("mtlo_lo_old", lo, model_lo);
    @(negedge clk);
    e_valid = 1'b0;
    e_op = OP_NONE;
    #1;
    checkOutput("mtlo_lo", lo, 32'h9ABC_DEF0);
    checkOutput("mtlo_hi_kept", hi, 32'h1234_5678);
    checkOutput("mt_done", done, 0);
    model_hi = 32'h1234_5678;
    model_lo = 32'h9ABC_DEF0;
    applyStimulus(OP_MULT, 32'h0001_0000, 32'h0003_0000, 32'd3, 32'd0, MC, MC, "mult_after_mt");

    // Flush during DIV_RUN iteration 10.
    @(negedge clk);
    e_valid = 1'b1;
    e_op = OP_DIV;
    e_src_a = 32'd1000;
    e_src_b = 32'd3;
    #1;
    checkOutput("divflush_accept_stall", stall_req, 1);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      e_valid = 1'b0;
      e_op = OP_NONE;
    end
    #1;
    checkOutput("divflush_run_stall", stall_req, 1);
    flush = 1'b1;
    #1;
    checkOutput("divflush_stall", stall_req, 0);
    checkOutput("divflush_done", done, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("divflush_idle_stall", stall_req, 0);
    countDone(36, "divflush");

    // Flush in the MUL completion cycle.
    @(negedge clk);
    e_valid = 1'b1;
    e_op = OP_MULTU;
    e_src_a = 32'd6;
    e_src_b = 32'd7;
    for (int i = 0; i < MC; i++) begin
      @(negedge clk);
      e_valid = 1'b0;
      e_op = OP_NONE;
    end
    flush = 1'b1;
    #1;
    checkOutput("mulflush_done", done, 0);
    checkOutput("mulflush_stall", stall_req, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("mulflush_idle_stall", stall_req, 0);
    countDone(MC + 2, "mulflush");

    // Flush in IDLE blocks both accept and MTHI.
    @(negedge clk);
    flush = 1'b1;
    e_valid = 1'b1;
    e_op = OP_MULT;
    e_src_a = 32'd5;
    e_src_b = 32'd5;
    #1;
    checkOutput("idleflush_stall", stall_req, 0);
    @(negedge clk);
    e_op = OP_MTHI;
    e_src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    flush = 1'b0;
    e_valid = 1'b0;
    e_op = OP_NONE;
    #1;
    checkOutput("idleflush_no_accept", stall_req, 0);
    countDone(MC + 2, "idleflush");

    // Reset in the middle of a divide, then a fresh divide.
    @(negedge clk);
    e_valid = 1'b1;
    e_op = OP_DIVU;
    e_src_a = 32'd12345;
    e_src_b = 32'd17;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e_valid = 1'b0;
      e_op = OP_NONE;
    end
    rst = 1'b1;
    #1;
    checkOutput("rstdiv_stall", stall_req, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstdiv_hi", hi, 0);
    checkOutput("rstdiv_lo", lo, 0);
    checkOutput("rstdiv_stall_after", stall_req, 0);
    checkOutput("rstdiv_done", done, 0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    applyStimulus(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 33, 33, "div_after_rst");

    // Randomized instruction stream against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = 32'($urandom_range(1, 100));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      refModel(rop, ra, rb, model_hi, model_lo, rhi, rlo, rdone, rstalls);
      applyStimulus(rop, ra, rb, rhi, rlo, rdone, rstalls, $sformatf("rand%0d_op%0d", n, rop));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
